// File: rtl/multi_trigger.sv
// multi_trigger: per-channel synchroniser, debounce filter, mode-selectable
// edge detector, one-cycle event pulse and sticky pending flag, plus a
// masked interrupt summary.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   signal_in  raw asynchronous inputs, bit i = channel i
//   mode       per-channel mode [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr        per-channel pending clear (level)
//   irq_en     per-channel interrupt mask
//   level      debounced, synchronised level
//   triggered  one-cycle event pulse
//   pending    sticky event flags
//   irq        OR of (pending & irq_en)
module multi_trigger #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   signal_in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  input  logic [CH-1:0]   irq_en,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   triggered,
  output logic [CH-1:0]   pending,
  output logic            irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CH-1:0][CNT_W-1:0]       cnt_q;
  logic [CH-1:0][CNT_W-1:0]       cnt_d;
  logic [CH-1:0]                  s_c;
  logic [CH-1:0]                  level_d;
  logic [CH-1:0]                  trig_d;
  logic [CH-1:0]                  pending_d;

  // Debounce and edge qualification; a level change resets the count.
  always_comb begin
    s_c     = '0;
    level_d = level;
    cnt_d   = cnt_q;
    trig_d  = '0;
    for (int i = 0; i < int'(CH); i++) begin
      s_c[i] = sync_q[i][SYNC_STAGES-1];
      if (s_c[i] == level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s_c[i];
        cnt_d[i]   = '0;
        case (mode[2*i +: 2])
          2'b01:   trig_d[i] = s_c[i];
          2'b10:   trig_d[i] = ~s_c[i];
          2'b11:   trig_d[i] = 1'b1;
          default: trig_d[i] = 1'b0;
        endcase
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // A new event outranks a simultaneous clear.
    pending_d = trig_d | (pending & ~clr);
  end

  // State registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level     <= '0;
      triggered <= '0;
      pending   <= '0;
      irq       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal_in[i]};
      end
      cnt_q     <= cnt_d;
      level     <= level_d;
      triggered <= trig_d;
      pending   <= pending_d;
      irq       <= |(pending_d & irq_en);
    end
  end

endmodule

// File: tb/tb_multi_trigger.sv
// Bench for multi_trigger: a default instance (4 ch, 2 sync, 4 debounce) and
// a fast instance (1 ch, 3 sync, no filtering), both checked every cycle
// against a window-based behavioural model, plus directed literal checks.
module tb_multi_trigger;

  localparam int SS_A = 2, DB_A = 4;
  localparam int SS_B = 3, DB_B = 1;
  localparam int NCH  = 5;  // model channels 0..3 = instance A, 4 = instance B

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] signal_in = '0, clr = '0, irq_en = '0;
  logic [7:0] mode = '0;
  logic [3:0] level_a, trig_a, pend_a;
  logic       irq_a;
  logic       sig_b = 1'b0, clr_b = 1'b0, en_b = 1'b0;
  logic [1:0] mode_b = '0;
  logic       level_b, trig_b, pend_b, irq_b;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  multi_trigger dut_a (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clr(clr),
    .irq_en(irq_en), .level(level_a), .triggered(trig_a), .pending(pend_a),
    .irq(irq_a)
  );

  multi_trigger #(.CH(1), .SYNC_STAGES(SS_B), .DB_CYCLES(DB_B), .CNT_W(1)) dut_b (
    .clk(clk), .rst(rst), .signal_in(sig_b), .mode(mode_b), .clr(clr_b),
    .irq_en(en_b), .level(level_b), .triggered(trig_b), .pending(pend_b),
    .irq(irq_b)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Behavioural model: the synchroniser is a plain delay line of SS samples;
  // a level flips once the last DB synchronised samples since the previous
  // flip all disagree with it.
  bit dq[NCH][$];
  bit sq[NCH][$];
  bit m_lvl[NCH], m_trig[NCH], m_pend[NCH];
  bit m_irq_a, m_irq_b;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      int ss, db;
      bit raw, cl, s, flip;
      logic [1:0] md;
      ss  = (c < 4) ? SS_A : SS_B;
      db  = (c < 4) ? DB_A : DB_B;
      raw = (c < 4) ? signal_in[c] : sig_b;
      cl  = (c < 4) ? clr[c] : clr_b;
      md  = (c < 4) ? mode[2*c +: 2] : mode_b;
      if (!rst) begin
        dq[c].delete();
        for (int k = 0; k < ss; k++) dq[c].push_back(1'b0);
        sq[c].delete();
        m_lvl[c] = 0; m_trig[c] = 0; m_pend[c] = 0;
      end else begin
        s = dq[c].pop_front();
        dq[c].push_back(raw);
        sq[c].push_back(s);
        if (sq[c].size() > db) void'(sq[c].pop_front());
        flip = (sq[c].size() == db);
        for (int k = 0; k < sq[c].size(); k++)
          if (sq[c][k] == m_lvl[c]) flip = 0;
        m_trig[c] = 0;
        if (flip) begin
          m_lvl[c] = s;
          sq[c].delete();
          m_trig[c] = s ? md[0] : md[1];  // bit0 enables rising, bit1 falling
        end
        m_pend[c] = m_trig[c] | (m_pend[c] & !cl);
      end
    end
    m_irq_a = 0;
    for (int c = 0; c < 4; c++) if (m_pend[c] && irq_en[c] && rst) m_irq_a = 1;
    m_irq_b = rst && m_pend[4] && en_b;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      logic [3:0] el, et, ep;
      for (int c = 0; c < 4; c++) begin
        el[c] = m_lvl[c]; et[c] = m_trig[c]; ep[c] = m_pend[c];
      end
      check("model level_a", 32'(level_a), 32'(el));
      check("model triggered_a", 32'(trig_a), 32'(et));
      check("model pending_a", 32'(pend_a), 32'(ep));
      check("model irq_a", 32'(irq_a), 32'(m_irq_a));
      check("model level_b", 32'(level_b), 32'(m_lvl[4]));
      check("model triggered_b", 32'(trig_b), 32'(m_trig[4]));
      check("model pending_b", 32'(pend_b), 32'(m_pend[4]));
      check("model irq_b", 32'(irq_b), 32'(m_irq_b));
    end
  end

  initial begin
    int cnt2, cnt3, p3, hi1, t1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset level", 32'(level_a), 32'h0);
    check("reset triggered", 32'(trig_a), 32'h0);
    check("reset pending", 32'(pend_a), 32'h0);
    check("reset irq", 32'(irq_a), 32'h0);
    started = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // ch0 rising, mode 01: level and pulse at edge 5
    mode = 8'h01; irq_en = 4'b0001; signal_in[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check("s1 level0 early", 32'(level_a[0]), 32'h0);
        check("s1 trig0 early", 32'(trig_a[0]), 32'h0);
      end
      if (k == 5) begin
        check("s1 level0", 32'(level_a[0]), 32'h1);
        check("s1 trig0", 32'(trig_a[0]), 32'h1);
        check("s1 pend0", 32'(pend_a[0]), 32'h1);
        check("s1 irq", 32'(irq_a), 32'h1);
      end
      if (k == 6) check("s1 trig0 one cycle", 32'(trig_a[0]), 32'h0);
    end

    // ch1 mode 10: glitch, clean high, then fall
    mode = 8'b0000_1001;
    signal_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    signal_in[1] = 1'b0;
    hi1 = 0;
    repeat (12) begin @(negedge clk); if (level_a[1]) hi1++; end
    check("s2 glitch no level", 32'(hi1), 32'h0);
    signal_in[1] = 1'b1;
    t1 = 0;
    repeat (10) begin @(negedge clk); if (trig_a[1]) t1++; end
    check("s2 high level1", 32'(level_a[1]), 32'h1);
    check("s2 rise no pulse", 32'(t1), 32'h0);
    signal_in[1] = 1'b0;
    t1 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (trig_a[1]) t1++;
      if (k == 5) check("s2 fall pulse", 32'(trig_a[1]), 32'h1);
    end
    check("s2 one pulse", 32'(t1), 32'h1);

    // ch2 both edges, ch3 off
    mode = 8'b0011_1001;
    cnt2 = 0; cnt3 = 0; p3 = 0;
    for (int t = 0; t < 4; t++) begin
      signal_in[3:2] = ~signal_in[3:2];
      repeat (10) begin
        @(negedge clk);
        if (trig_a[2]) cnt2++;
        if (trig_a[3]) cnt3++;
        if (pend_a[3]) p3++;
      end
      check("s3 level3 tracks", 32'(level_a[3]), 32'(signal_in[3]));
    end
    check("s3 ch2 pulses", 32'(cnt2), 32'd4);
    check("s3 ch3 no pulses", 32'(cnt3), 32'h0);
    check("s3 ch3 no pending", 32'(p3), 32'h0);

    // Set beats simultaneous clear, then clear alone
    mode[1:0] = 2'b11;
    check("s4 pend0 before", 32'(pend_a[0]), 32'h1);
    signal_in[0] = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) clr[0] = 1'b1;
      if (k == 5) begin
        check("s4 trig0", 32'(trig_a[0]), 32'h1);
        check("s4 set wins", 32'(pend_a[0]), 32'h1);
        check("s4 irq held", 32'(irq_a), 32'h1);
      end
      if (k == 6) begin
        check("s4 cleared", 32'(pend_a[0]), 32'h0);
        check("s4 irq falls", 32'(irq_a), 32'h0);
        clr[0] = 1'b0;
      end
    end

    // Inputs held high through reset asserted mid-debounce
    mode = 8'h55; signal_in = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("s5 rst level", 32'(level_a), 32'h0);
      check("s5 rst trig", 32'(trig_a), 32'h0);
      check("s5 rst pend", 32'(pend_a), 32'h0);
      check("s5 rst irq", 32'(irq_a), 32'h0);
    end
    rst = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) check("s5 no early pulse", 32'(trig_a), 32'h0);
      if (k == 5) begin
        check("s5 all pulse", 32'(trig_a), 32'hF);
        check("s5 all level", 32'(level_a), 32'hF);
      end
    end

    // Fast instance: single-cycle high gives rise then fall pulse
    mode_b = 2'b11; en_b = 1'b1;
    repeat (3) @(negedge clk);
    sig_b = 1'b1;
    @(negedge clk);
    sig_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) check("s6 no early", 32'(trig_b), 32'h0);
      if (k == 3) begin
        check("s6 rise level", 32'(level_b), 32'h1);
        check("s6 rise pulse", 32'(trig_b), 32'h1);
        check("s6 pend", 32'(pend_b), 32'h1);
        check("s6 irq", 32'(irq_b), 32'h1);
      end
      if (k == 4) begin
        check("s6 fall level", 32'(level_b), 32'h0);
        check("s6 fall pulse", 32'(trig_b), 32'h1);
      end
      if (k == 5) check("s6 pulse end", 32'(trig_b), 32'h0);
    end

    // Randomised traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) signal_in = signal_in ^ 4'($urandom);
      if ($urandom_range(0, 2) == 0) sig_b = ~sig_b;
      if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 31) == 0) mode_b = 2'($urandom);
      if ($urandom_range(0, 63) == 0) irq_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) en_b = 1'($urandom);
      clr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      clr_b = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_trigger.md
Name: multi_trigger

Overview:
- Parametrised, multi-channel successor to the single-channel falling-edge trigger.
- Per channel: input synchroniser, debounce filter, mode-selectable edge detection (off / rising / falling / both), one-cycle event pulse, and a sticky pending flag with software clear.
- A masked interrupt summary is also provided.
- Sits between raw button/sensor inputs and the term-project control FSM.

Parameters:
- CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DB_CYCLES, 4, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- signal_in  in  CH  raw asynchronous inputs, bit i = channel i.
- mode  in  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr  in  CH  per-channel pending clear, level-sensitive, sampled each edge.
- irq_en  in  CH  per-channel interrupt mask.
- level  out  CH  debounced, synchronised level.
- triggered  out  CH  one-cycle event pulse per channel.
- pending  out  CH  sticky event flags.
- irq  out  1  OR of (pending & irq_en), registered.

Behaviour:
- Reset (rst=0 at a rising edge): sync chain, level, debounce counter, triggered, pending and irq all clear to 0. Reset dominates every other input. Asserting reset mid-debounce discards the partial count.
- Synchroniser: signal_in[i] shifts through SYNC_STAGES flops. The last stage is s[i].
- Debounce, each edge per channel:
  - If s == level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: level <= s, cnt <= 0, and an edge is detected (rising if s=1, falling if s=0).
  - Else: cnt <= cnt+1.
- Excursions on s shorter than DB_CYCLES cycles produce no level change and no pulse.
- Latency: if signal_in is stable from before edge 0, level changes at edge SYNC_STAGES+DB_CYCLES-1. triggered is high for exactly the following cycle, coincident with the new level.
- triggered[i] <= edge detected AND mode qualifies. Qualifying cases: 01 needs a rising edge, 10 a falling edge, 11 either. 00 never qualifies.
  - Mode is sampled at the edge where the level changes.
  - Changing mode never disturbs the level or the counter.
  - At most one pulse per level change. Pulses on different channels are independent and may coincide.
- pending[i]:
  - Set on the edge where triggered[i] is registered high.
  - Cleared by clr[i]=1.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Holds otherwise.
- irq <= |(next pending & irq_en). It asserts in the same cycle pending becomes visible.
- Because level resets to 0, an input held high through reset produces a rising event SYNC_STAGES+DB_CYCLES edges after reset release. This is intentional.
- Adjacent opposite edges are at least DB_CYCLES cycles apart, so triggered is never high in two consecutive cycles when DB_CYCLES>=2.

Test Plan:
- Defaults; mode=01 on ch0. Raise signal_in[0] and hold. Required: level[0] and triggered[0] rise at edge 5 after the first sampling edge. triggered[0] is high exactly 1 cycle. pending[0]=1. irq=1 iff irq_en[0]=1.
- Defaults; ch1 mode=10. Apply a 3-cycle high glitch on signal_in[1], then a clean high for 10 cycles followed by low. Required: glitch gives no level change. Clean high gives level=1 but no pulse. Return to low gives one triggered[1] pulse, 6 edges after the fall.
- ch2 mode=11 and ch3 mode=00; toggle both inputs with 10-cycle stable periods. Required: ch2 pulses on every accepted change. ch3 level tracks its input, but triggered[3] and pending[3] stay 0.
- With pending[0]=1, assert clr[0] on the same edge a new ch0 event registers. Required: pending[0] stays 1. A clr[0] alone on the next edge clears it, and irq falls the same cycle.
- Hold signal_in=4'b1111 through reset, with rst low for 3 edges mid-debounce, then release; all modes=01. Required: all outputs 0 during reset. All four channels pulse together 6 edges after release.
- DB_CYCLES=1, SYNC_STAGES=3 instance. A single-cycle high (after synchronisation) on ch0 with mode=11 yields a rising pulse and then a falling pulse, at the edges predicted by the latency formula.
